// File: rtl/ir_receiver_if.sv
// ir_receiver_if: groups the IR line input and the decoded-message outputs of the IR receiver.
// Signals: ir_in (raw IR line), msg[7:0], msg_valid (1-cycle strobe), err (1-cycle strobe), busy.
// modport master = the receiver (drives message side); modport slave = the consumer (drives ir_in).
interface ir_receiver_if;
    logic       ir_in;
    logic [7:0] msg;
    logic       msg_valid;
    logic       err;
    logic       busy;

    modport master (
        input  ir_in,
        output msg,
        output msg_valid,
        output err,
        output busy
    );

    modport slave (
        output ir_in,
        input  msg,
        input  msg_valid,
        input  err,
        input  busy
    );
endinterface

// File: rtl/ir_receiver.sv
// Purpose: decodes an 8-bit LSB-first pulse-width IR frame (3-tick mark = 1, 1-tick mark = 0).
// Latency: msg_valid 3 cycles after the final mark falls (+FILTER_LEN with IR_RX_GLITCH_FILTER_EN).
// Backpressure: none; msg_valid/err are single-cycle strobes, msg holds until the next good frame.
// Ports: clk, rst (async active-high), bus (ir_receiver_if.master: ir_in, msg, msg_valid, err, busy).
// Option: define IR_RX_GLITCH_FILTER_EN to insert a FILTER_LEN-cycle stability filter after the synchronizer.
module ir_receiver #(
    parameter int CLK_PER_TICK = 20000,
    parameter int CNT_W        = 24,
    parameter int INVERT       = 0,
    parameter int FILTER_LEN   = 8
) (
    input  logic          clk,
    input  logic          rst,
    ir_receiver_if.master bus
);

    // Counter must be able to represent the space timeout.
    generate
        if (CNT_W < $clog2(5 * CLK_PER_TICK + 1) || FILTER_LEN < 1) begin : g_bad_cfg
            $error("ir_receiver: CNT_W too small or FILTER_LEN < 1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] MIN_MARK = CNT_W'(CLK_PER_TICK / 2);
    localparam logic [CNT_W-1:0] ONE_TH   = CNT_W'(2 * CLK_PER_TICK);
    localparam logic [CNT_W-1:0] MAX_MARK = CNT_W'(4 * CLK_PER_TICK);
    localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(5 * CLK_PER_TICK);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE,
        WAIT_LOW
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: optional inversion, then 2-flop synchronizer.
    // ------------------------------------------------------------------
    logic ir_raw;
    logic sync1;
    logic s;
    logic lvl;   // level seen by the FSM

    assign ir_raw = (INVERT != 0) ? ~bus.ir_in : bus.ir_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= ir_raw;
            s     <= sync1;
        end
    end

`ifdef IR_RX_GLITCH_FILTER_EN
    // f follows s only after s has differed from f for FILTER_LEN straight
    // cycles. Both edges see the same delay, so measured widths are unchanged.
    localparam int FW = $clog2(FILTER_LEN + 1);
    logic          f;
    logic [FW-1:0] fcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f    <= 1'b0;
            fcnt <= '0;
        end else if (s == f) begin
            fcnt <= '0;
        end else if (fcnt == FW'(FILTER_LEN - 1)) begin
            f    <= s;
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + FW'(1);
        end
    end

    assign lvl = f;
`else
    assign lvl = s;
`endif

    // ------------------------------------------------------------------
    // Decode FSM
    // ------------------------------------------------------------------
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bitcnt, bitcnt_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic [7:0]       msg_q, msg_nxt;
    logic             vld_q, vld_nxt;
    logic             err_q, err_nxt;

    logic [CNT_W-1:0] cnt_inc;
    logic             bit_val;
    logic [7:0]       shifted;

    // Saturating increment: a stuck line never wraps the counter.
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_ONE;
    assign bit_val = (cnt >= ONE_TH);
    assign shifted = {bit_val, shreg[7:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            msg_q  <= '0;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            bitcnt <= bitcnt_nxt;
            shreg  <= shreg_nxt;
            msg_q  <= msg_nxt;
            vld_q  <= vld_nxt;
            err_q  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        bitcnt_nxt = bitcnt;
        shreg_nxt  = shreg;
        msg_nxt    = msg_q;
        vld_nxt    = 1'b0;
        err_nxt    = 1'b0;

        case (state)
            IDLE: begin
                // Low time here (stalls, inter-frame gaps) is simply ignored.
                if (lvl) begin
                    cnt_nxt    = CNT_ONE;
                    bitcnt_nxt = '0;
                    state_nxt  = MARK;
                end
            end

            MARK: begin
                if (lvl) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc >= MAX_MARK) begin
                        // Mark too long: flag once, then ignore until the line drops.
                        err_nxt   = 1'b1;
                        state_nxt = WAIT_LOW;
                    end
                end else if (cnt < MIN_MARK) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    shreg_nxt  = shifted;
                    bitcnt_nxt = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        // 8th falling edge closes the frame; no space is awaited.
                        msg_nxt   = shifted;
                        vld_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt   = CNT_ONE;
                        state_nxt = SPACE;
                    end
                end
            end

            SPACE: begin
                if (!lvl) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc >= TIMEOUT) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt   = CNT_ONE;
                    state_nxt = MARK;
                end
            end

            WAIT_LOW: begin
                if (!lvl) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.msg       = msg_q;
    assign bus.msg_valid = vld_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state != IDLE);

endmodule
